vrased_reset_ctrl: RTL and testbench

// Downstream consumer of the per-monitor reset requests (DMA/stack, key access, atomicity, ...).

---
 rtl/vrased_reset_ctrl.sv | 98 +++++++++
 tb/tb_vrased_reset_ctrl.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/vrased_reset_ctrl.sv
// vrased_reset_ctrl: merges monitor violation requests into a held system
// reset, releases only at the reset handler, and records violation causes.
module vrased_reset_ctrl #(
  parameter int          N_SRC         = 4,
  parameter int          HOLD_CYCLES   = 8,
  parameter int          CNT_W         = 8,
  parameter logic [15:0] RESET_HANDLER = 16'h0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [15:0]      pc,
  input  logic [N_SRC-1:0] viol_req,
  input  logic             cause_clr,
  output logic             sys_reset,
  output logic [N_SRC-1:0] cause,
  output logic [N_SRC-1:0] last_cause,
  output logic [CNT_W-1:0] viol_cnt,
  output logic [1:0]       state_o
);

  localparam int HW =
    (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0] HOLD_LD =
    HW'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_KILL = 2'b01,
    ST_WAIT = 2'b10,
    ST_BAD  = 2'b11
  } state_t;

  state_t          state;
  logic [HW-1:0]   hold_cnt;
  logic            any_req;
  logic            pc_hit;

  assign any_req   = |viol_req;
  assign pc_hit    = (pc == RESET_HANDLER);
  assign sys_reset = (state != ST_RUN);
  assign state_o   = state;

  // Episode FSM: hold timer, last-cause capture and violation count.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_KILL;
      hold_cnt   <= HOLD_LD;
      last_cause <= '0;
      viol_cnt   <= '0;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (any_req) begin
            state      <= ST_KILL;
            hold_cnt   <= HOLD_LD;
            last_cause <= viol_req;
            if (viol_cnt != CNT_MAX)
              viol_cnt <= viol_cnt + CNT_W'(1);
          end
        end
        ST_KILL: begin
          if (any_req) begin
            hold_cnt <= HOLD_LD;
          end else if (hold_cnt == '0) begin
            state <= ST_WAIT;
          end else begin
            hold_cnt <= hold_cnt - HW'(1);
          end
        end
        ST_WAIT: begin
          if (any_req) begin
            state    <= ST_KILL;
            hold_cnt <= HOLD_LD;
          end else if (pc_hit) begin
            state <= ST_RUN;
          end
        end
        default: begin
          state    <= ST_KILL;
          hold_cnt <= HOLD_LD;
        end
      endcase
    end
  end

  // Sticky cause: accumulates always, clear only honoured while running.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cause <= '0;
    end else if (state == ST_RUN && cause_clr) begin
      cause <= viol_req;
    end else begin
      cause <= cause | viol_req;
    end
  end

endmodule

// File: tb/tb_vrased_reset_ctrl.sv
// tb_vrased_reset_ctrl: directed stimulus against a quiet-time episode
// model, plus literal checkpoints for the reset controller.
module tb_vrased_reset_ctrl;

  localparam int HOLD = 8;
  localparam logic [15:0] RH = 16'h0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [15:0] pc;
  logic [3:0]  viol_req;
  logic        cause_clr;

  logic        sys_reset, sys_reset2;
  logic [3:0]  cause, last_cause, cause2, last_cause2;
  logic [7:0]  viol_cnt;
  logic [1:0]  viol_cnt2;
  logic [1:0]  state_o, state2;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  vrased_reset_ctrl dut (
    .clk(clk), .reset_n(reset_n), .pc(pc),
    .viol_req(viol_req), .cause_clr(cause_clr),
    .sys_reset(sys_reset), .cause(cause),
    .last_cause(last_cause), .viol_cnt(viol_cnt),
    .state_o(state_o)
  );

  vrased_reset_ctrl #(.CNT_W(2)) dut2 (
    .clk(clk), .reset_n(reset_n), .pc(pc),
    .viol_req(viol_req), .cause_clr(cause_clr),
    .sys_reset(sys_reset2), .cause(cause2),
    .last_cause(last_cause2), .viol_cnt(viol_cnt2),
    .state_o(state2)
  );

  // Model: an episode is left once HOLD request-free cycles have
  // elapsed and the handler pc is seen with no request.
  bit       released;
  int       quiet;
  int       m_cnt;
  logic [3:0] m_cause, m_last;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      released = 1'b0;
      quiet    = 0;
      m_cnt    = 0;
      m_cause  = '0;
      m_last   = '0;
    end else begin
      if (released && cause_clr) m_cause = viol_req;
      else m_cause = m_cause | viol_req;
      if (released) begin
        if (|viol_req) begin
          released = 1'b0;
          quiet    = 0;
          m_cnt++;
          m_last   = viol_req;
        end
      end else if (|viol_req) begin
        quiet = 0;
      end else if (quiet >= HOLD && pc == RH) begin
        released = 1'b1;
      end else if (quiet < HOLD) begin
        quiet++;
      end
    end
  end

  function automatic int exp_state();
    if (released) return 0;
    if (quiet < HOLD) return 1;
    return 2;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_state", int'(state_o), exp_state());
      chk("m_sys_reset", int'(sys_reset), int'(exp_state() != 0));
      chk("m_cause", int'(cause), int'(m_cause));
      chk("m_last_cause", int'(last_cause), int'(m_last));
      chk("m_viol_cnt", int'(viol_cnt), (m_cnt > 255) ? 255 : m_cnt);
      chk("m_viol_cnt2", int'(viol_cnt2), (m_cnt > 3) ? 3 : m_cnt);
      chk("m_state2", int'(state2), exp_state());
    end
  end

  task automatic step(input logic [3:0] r, input logic [15:0] p,
                      input logic c);
    viol_req  = r;
    pc        = p;
    cause_clr = c;
    @(posedge clk);
    #2;
    viol_req  = '0;
    cause_clr = 1'b0;
  endtask

  task automatic idle(input int n, input logic [15:0] p);
    for (int i = 0; i < n; i++) step(4'b0000, p, 1'b0);
  endtask

  initial begin
    reset_n   = 1'b0;
    pc        = 16'h0000;
    viol_req  = '0;
    cause_clr = 1'b0;
    cmp_en    = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    chk("rst_sys_reset", int'(sys_reset), 1);
    chk("rst_state", int'(state_o), 1);
    chk("rst_cnt", int'(viol_cnt), 0);
    chk("rst_cause", int'(cause), 0);
    reset_n = 1'b1;

    // T1: power-on episode, 8 KILL cycles, 1 WAIT, then RUN.
    idle(7, 16'h0000);
    chk("t1_kill7", int'(state_o), 1);
    idle(1, 16'h0000);
    chk("t1_wait", int'(state_o), 2);
    chk("t1_wait_rst", int'(sys_reset), 1);
    idle(1, 16'h0000);
    chk("t1_run", int'(sys_reset), 0);
    chk("t1_cnt", int'(viol_cnt), 0);

    // T2: single-cycle violation from RUN.
    step(4'b0010, 16'h0000, 1'b0);
    chk("t2_sys_reset", int'(sys_reset), 1);
    chk("t2_state", int'(state_o), 1);
    chk("t2_cause", int'(cause), 4'b0010);
    chk("t2_last", int'(last_cause), 4'b0010);
    chk("t2_cnt", int'(viol_cnt), 1);

    // T3: new request in KILL restarts hold.
    idle(4, 16'h0000);
    step(4'b1000, 16'h0000, 1'b0);
    chk("t3_cause", int'(cause), 4'b1010);
    chk("t3_last", int'(last_cause), 4'b0010);
    chk("t3_cnt", int'(viol_cnt), 1);
    idle(7, 16'h0000);
    chk("t3_still_kill", int'(state_o), 1);
    idle(1, 16'h0000);
    chk("t3_wait", int'(state_o), 2);

    // T4: pc match with request re-kills; wrong pc waits forever.
    step(4'b0001, 16'h0000, 1'b0);
    chk("t4_rekill", int'(state_o), 1);
    chk("t4_cnt", int'(viol_cnt), 1);
    chk("t4_last", int'(last_cause), 4'b0010);
    idle(8, 16'h4400);
    idle(20, 16'h4400);
    chk("t4_wait", int'(state_o), 2);
    chk("t4_wait_rst", int'(sys_reset), 1);
    idle(1, 16'h0000);
    chk("t4_run", int'(state_o), 0);

    // T6: clear racing a new request; clear ignored outside RUN.
    step(4'b0000, 16'h0000, 1'b1);
    chk("t6_clr", int'(cause), 0);
    step(4'b0110, 16'h0000, 1'b0);
    idle(9, 16'h0000);
    chk("t6_run", int'(state_o), 0);
    chk("t6_cause_pre", int'(cause), 4'b0110);
    step(4'b0001, 16'h0000, 1'b1);
    chk("t6_cause", int'(cause), 4'b0001);
    chk("t6_cnt", int'(viol_cnt), 3);
    step(4'b0000, 16'h0000, 1'b1);
    chk("t6_clr_ignored", int'(cause), 4'b0001);
    idle(3, 16'h0000);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_cause", int'(cause), 0);
    chk("t6_rst_cnt", int'(viol_cnt), 0);
    chk("t6_rst_last", int'(last_cause), 0);
    chk("t6_rst_state", int'(state_o), 1);
    #1;
    reset_n = 1'b1;
    @(posedge clk);
    #2;
    idle(6, 16'h0000);
    chk("t6_hold_restart", int'(state_o), 1);
    idle(1, 16'h0000);
    chk("t6_hold_wait", int'(state_o), 2);
    idle(1, 16'h0000);
    chk("t6_run2", int'(state_o), 0);

    // T5: repeated episodes saturate the narrow counter.
    for (int e = 0; e < 5; e++) begin
      step(4'b0100, 16'h0000, 1'b0);
      idle(9, 16'h0000);
      if (e == 2) chk("t5_cnt2_3", int'(viol_cnt2), 3);
    end
    chk("t5_cnt2_sat", int'(viol_cnt2), 3);
    chk("t5_cnt", int'(viol_cnt), 5);
    chk("t5_run", int'(state_o), 0);

    @(negedge clk);
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
